waitstate_mem_io: RTL

Parametrised 8088-bus memory/IO slave with internal address decode, programmable wait states, READY generation and optional write protection. It is the next-generation memory or I/O unit on the 8088 bus: it decodes its own window instead of relying on an external chip select, and holds read data for the full strobe. It stretches slow accesses through READY and flags illegal writes to ROM-mode instances. Several instances sit side by side on the shared ADDRESS/DATA bus, each with its own BASE_ADDR and IO_SPACE.

---
 rtl/waitstate_mem_io_if.sv | 23 ++
 rtl/waitstate_mem_io.sv | 125 ++++++++++++
 2 files changed

// File: rtl/waitstate_mem_io_if.sv
// 8088 bus control and address signals shared between a bus master and a memory/IO slave.
// DATA is kept as a plain inout port on the slave so tristate resolution stays at module level.
interface waitstate_mem_io_if #(
  parameter int unsigned ADDR_WIDTH = 20
);
  logic                  ALE;
  logic                  IOM;
  logic                  RD;
  logic                  WR;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic                  READY;
  logic                  WP_ERR;

  modport master (
    output ALE, IOM, RD, WR, ADDRESS,
    input  READY, WP_ERR
  );

  modport slave (
    input  ALE, IOM, RD, WR, ADDRESS,
    output READY, WP_ERR
  );
endinterface

// File: rtl/waitstate_mem_io.sv
// 8088-bus memory/IO slave: decodes its own window, stretches accesses with READY wait states,
// and records write attempts on read-only instances in a sticky WP_ERR flag.
module waitstate_mem_io #(
  parameter int unsigned          ADDR_WIDTH     = 20,
  parameter int unsigned          MEM_ADDR_WIDTH = 16,
  parameter int unsigned          DATA_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter bit                   IO_SPACE       = 1'b0,
  parameter int unsigned          READ_WAIT      = 0,
  parameter int unsigned          WRITE_WAIT     = 0,
  parameter bit                   READ_ONLY      = 1'b0,
  parameter string                INIT_FILE      = ""
) (
  input  logic                  CLK,
  input  logic                  RESET,
  waitstate_mem_io_if.slave     bus,
  inout  wire  [DATA_WIDTH-1:0] DATA
);

  localparam int unsigned Depth  = 2 ** MEM_ADDR_WIDTH;
  localparam logic [3:0]  RdLoad = (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;
  localparam logic [3:0]  WrLoad = (WRITE_WAIT > 0) ? 4'(WRITE_WAIT - 1) : 4'd0;

  typedef enum logic [6:0] {
    StIdle    = 7'b0000001,
    StLatched = 7'b0000010,
    StRwait   = 7'b0000100,
    StRead    = 7'b0001000,
    StWwait   = 7'b0010000,
    StWrite   = 7'b0100000,
    StWdone   = 7'b1000000
  } state_e;

  state_e                    r_state;
  state_e                    w_state_next;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [3:0]                r_cnt;
  logic [3:0]                w_cnt_next;
  logic                      r_wp_err;
  logic                      w_hit;
  logic                      w_latch;
  logic                      w_drive;
  logic [DATA_WIDTH-1:0]     r_mem [Depth];

  assign w_hit = (bus.ADDRESS[ADDR_WIDTH-1:MEM_ADDR_WIDTH] ==
                  BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH]) && (bus.IOM == IO_SPACE);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.ALE && w_hit) begin
          w_state_next = StLatched;
          w_latch      = 1'b1;
        end
      end
      StLatched: begin
        // A new ALE outranks strobes; RD outranks WR if both are low.
        if (bus.ALE) begin
          if (w_hit) w_latch = 1'b1;
          else       w_state_next = StIdle;
        end else if (!bus.RD) begin
          if (READ_WAIT > 0) begin
            w_state_next = StRwait;
            w_cnt_next   = RdLoad;
          end else begin
            w_state_next = StRead;
          end
        end else if (!bus.WR) begin
          if (WRITE_WAIT > 0) begin
            w_state_next = StWwait;
            w_cnt_next   = WrLoad;
          end else begin
            w_state_next = StWrite;
          end
        end
      end
      StRwait: begin
        if (bus.RD)             w_state_next = StIdle;
        else if (r_cnt == 4'd0) w_state_next = StRead;
        else                    w_cnt_next   = r_cnt - 4'd1;
      end
      StRead: begin
        if (bus.RD) w_state_next = StIdle;
      end
      StWwait: begin
        if (bus.WR)             w_state_next = StIdle;
        else if (r_cnt == 4'd0) w_state_next = StWrite;
        else                    w_cnt_next   = r_cnt - 4'd1;
      end
      StWrite: w_state_next = StWdone;
      StWdone: begin
        if (bus.WR) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_cnt    <= 4'd0;
      r_wp_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) r_addr <= bus.ADDRESS[MEM_ADDR_WIDTH-1:0];
      if (r_state == StWrite && READ_ONLY) r_wp_err <= 1'b1;
    end
  end

  // Commit happens on the edge that leaves WRITE, so a coincident RESET cancels it.
  always_ff @(posedge CLK) begin
    if (!RESET && r_state == StWrite && !READ_ONLY) r_mem[r_addr] <= DATA;
  end

  assign w_drive    = (r_state == StRead);
  assign DATA       = w_drive ? r_mem[r_addr] : {DATA_WIDTH{1'bz}};
  assign bus.READY  = !((r_state == StRwait) || (r_state == StWwait));
  assign bus.WP_ERR = r_wp_err;

endmodule
